mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter that lets the hart's instruction-fetch and data-access interfaces share a single synchronous unified memory. It sits between the hart and the memory macro and issues at most one access per cycle. Data accesses win conflicts, and a starvation guard bounds fetch latency. Read data returns one cycle after issue and is steered back to the requester that issued the read.

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter: data wins conflicts, fetch is
// forced after STARVE_LIMIT consecutive data grants, responses steered back.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ivalid,
  input  logic [31:0]      i_iaddr,
  output logic             o_iready,
  output logic             o_irvalid,
  output logic [31:0]      o_irdata,
  input  logic             i_dvalid,
  input  logic             i_dwen,
  input  logic [31:0]      i_daddr,
  input  logic [31:0]      i_dwdata,
  input  logic [3:0]       i_dmask,
  output logic             o_dready,
  output logic             o_drvalid,
  output logic [31:0]      o_drdata,
  output logic             o_mem_en,
  output logic             o_mem_wen,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic [3:0]       o_mem_mask,
  input  logic [31:0]      i_mem_rdata,
  output logic [CNT_W-1:0] o_conflicts
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e           owner_q, owner_d;
  logic             store_q, store_d;
  logic [3:0]       starve_q, starve_d;
  logic [CNT_W-1:0] conf_q, conf_d;
  logic             gnt_i, gnt_d;

  // Grants are held low during reset so no access leaks out
  always_comb begin
    gnt_d = i_rst_n & i_dvalid & ~(i_ivalid & (starve_q == LIMIT));
    gnt_i = i_rst_n & i_ivalid & ~gnt_d;
  end

  always_comb begin
    starve_d = starve_q;
    owner_d  = OWN_NONE;
    store_d  = 1'b0;
    conf_d   = conf_q;
    if (gnt_i || !i_ivalid) begin
      starve_d = 4'd0;
    end else if (gnt_d && starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end
    unique case (1'b1)
      gnt_d: begin
        owner_d = OWN_DATA;
        store_d = i_dwen;
      end
      gnt_i:   owner_d = OWN_INST;
      default: owner_d = OWN_NONE;
    endcase
    if (i_ivalid && i_dvalid && !(&conf_q)) begin
      conf_d = conf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q  <= OWN_NONE;
      store_q  <= 1'b0;
      starve_q <= 4'd0;
      conf_q   <= '0;
    end else begin
      owner_q  <= owner_d;
      store_q  <= store_d;
      starve_q <= starve_d;
      conf_q   <= conf_d;
    end
  end

  assign o_iready    = gnt_i;
  assign o_dready    = gnt_d;
  assign o_mem_en    = gnt_i | gnt_d;
  assign o_mem_wen   = gnt_d & i_dwen;
  assign o_mem_addr  = gnt_d ? i_daddr :
                       gnt_i ? i_iaddr : 32'd0;
  assign o_mem_wdata = gnt_d ? i_dwdata : 32'd0;
  assign o_mem_mask  = gnt_d ? i_dmask :
                       gnt_i ? 4'hF : 4'h0;

  assign o_irvalid   = (owner_q == OWN_INST);
  assign o_drvalid   = (owner_q == OWN_DATA);
  assign o_irdata    = o_irvalid ? i_mem_rdata : 32'd0;
  assign o_drdata    = (o_drvalid && !store_q) ? i_mem_rdata : 32'd0;
  assign o_conflicts = conf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model
// and a second narrow-counter instance for saturation.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ivalid, dvalid, dwen;
  logic [31:0] iaddr, daddr, dwdata;
  logic [3:0]  dmask;
  logic [31:0] mem_rdata;

  logic        iready, irvalid, dready, drvalid;
  logic [31:0] irdata, drdata;
  logic        mem_en, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [15:0] conflicts;

  logic        s_iready, s_irvalid, s_dready, s_drvalid;
  logic [31:0] s_irdata, s_drdata;
  logic        s_mem_en, s_mem_wen;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_mask;
  logic [1:0]  s_conflicts;

  logic [31:0] mem [64];
  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ivalid(ivalid), .i_iaddr(iaddr),
    .o_iready(iready), .o_irvalid(irvalid), .o_irdata(irdata),
    .i_dvalid(dvalid), .i_dwen(dwen), .i_daddr(daddr),
    .i_dwdata(dwdata), .i_dmask(dmask),
    .o_dready(dready), .o_drvalid(drvalid), .o_drdata(drdata),
    .o_mem_en(mem_en), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_rdata(mem_rdata), .o_conflicts(conflicts)
  );

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ivalid(ivalid), .i_iaddr(iaddr),
    .o_iready(s_iready), .o_irvalid(s_irvalid), .o_irdata(s_irdata),
    .i_dvalid(dvalid), .i_dwen(dwen), .i_daddr(daddr),
    .i_dwdata(dwdata), .i_dmask(dmask),
    .o_dready(s_dready), .o_drvalid(s_drvalid), .o_drdata(s_drdata),
    .o_mem_en(s_mem_en), .o_mem_wen(s_mem_wen), .o_mem_addr(s_mem_addr),
    .o_mem_wdata(s_mem_wdata), .o_mem_mask(s_mem_mask),
    .i_mem_rdata(mem_rdata), .o_conflicts(s_conflicts)
  );

  // Synchronous memory: masked write, read data one cycle after issue
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b])
            mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[0]    = 32'h0000_0013;
    mem[4]    = 32'h0050_0093;
    mem[8]    = 32'h1122_3344;
    mem[16]   = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    ivalid = 1'b1; iaddr = 32'h10;
    dvalid = 1'b0; dwen = 1'b0; daddr = 32'h0;
    dwdata = 32'h0; dmask = 4'h0;
    #2;
    chk("rst_irvalid", {31'd0, irvalid}, 32'd0);
    chk("rst_drvalid", {31'd0, drvalid}, 32'd0);
    chk("rst_iready", {31'd0, iready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_conf", {16'd0, conflicts}, 32'd0);
    ivalid = 1'b0;
    #10 rst_n = 1'b1;
    tick();

    // fetch only
    ivalid = 1'b1; iaddr = 32'h10;
    #1;
    chk("f_iready", {31'd0, iready}, 32'd1);
    chk("f_dready", {31'd0, dready}, 32'd0);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_mask", {28'd0, mem_mask}, 32'hF);
    tick();
    ivalid = 1'b0;
    chk("f_irvalid", {31'd0, irvalid}, 32'd1);
    chk("f_irdata", irdata, 32'h0050_0093);
    chk("f_drvalid", {31'd0, drvalid}, 32'd0);
    tick();
    chk("f_idle", {31'd0, irvalid}, 32'd0);
    chk("f_idle_rd", irdata, 32'd0);

    // conflict: data wins, fetch next cycle
    ivalid = 1'b1; iaddr = 32'h0;
    dvalid = 1'b1; dwen = 1'b0; daddr = 32'h40; dmask = 4'hF;
    #1;
    chk("c_dready", {31'd0, dready}, 32'd1);
    chk("c_iready", {31'd0, iready}, 32'd0);
    chk("c_addr", mem_addr, 32'h40);
    tick();
    dvalid = 1'b0;
    #1;
    chk("c_drvalid", {31'd0, drvalid}, 32'd1);
    chk("c_drdata", drdata, 32'hDEAD_BEEF);
    chk("c_conf", {16'd0, conflicts}, 32'd1);
    chk("c_iready2", {31'd0, iready}, 32'd1);
    chk("c_addr2", mem_addr, 32'h0);
    tick();
    ivalid = 1'b0;
    chk("c_irvalid", {31'd0, irvalid}, 32'd1);
    chk("c_irdata", irdata, 32'h13);
    chk("c_drv0", {31'd0, drvalid}, 32'd0);

    // starvation: D,D,D,D,I,D,D,D,D,I
    ivalid = 1'b1; iaddr = 32'h10;
    dvalid = 1'b1; daddr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("s_dready%0d", i), {31'd0, dready},
          (i == 4 || i == 9) ? 32'd0 : 32'd1);
      chk($sformatf("s_iready%0d", i), {31'd0, iready},
          (i == 4 || i == 9) ? 32'd1 : 32'd0);
      tick();
    end
    ivalid = 1'b0; dvalid = 1'b0;
    chk("s_irvalid", {31'd0, irvalid}, 32'd1);
    chk("s_irdata", irdata, 32'h0050_0093);
    chk("s_conf", {16'd0, conflicts}, 32'd11);
    tick();

    // masked store then load back
    dvalid = 1'b1; dwen = 1'b1; daddr = 32'h20;
    dwdata = 32'hA5A5_A5A5; dmask = 4'b0011;
    #1;
    chk("w_wen", {31'd0, mem_wen}, 32'd1);
    chk("w_mask", {28'd0, mem_mask}, 32'h3);
    chk("w_wdata", mem_wdata, 32'hA5A5_A5A5);
    tick();
    dwen = 1'b0; dmask = 4'hF;
    #1;
    chk("w_ack", {31'd0, drvalid}, 32'd1);
    chk("w_ackdata", drdata, 32'd0);
    chk("w_ldready", {31'd0, dready}, 32'd1);
    chk("w_ldwen", {31'd0, mem_wen}, 32'd0);
    tick();
    dvalid = 1'b0;
    chk("w_ldvalid", {31'd0, drvalid}, 32'd1);
    chk("w_lddata", drdata, 32'h1122_A5A5);
    tick();

    // reset while a load response is outstanding
    dvalid = 1'b1; daddr = 32'h40;
    tick();
    dvalid = 1'b0;
    chk("r_pre", {31'd0, drvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_drvalid", {31'd0, drvalid}, 32'd0);
    chk("r_drdata", drdata, 32'd0);
    chk("r_conf", {16'd0, conflicts}, 32'd0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("r_after", {31'd0, drvalid}, 32'd0);
    chk("r_after_i", {31'd0, irvalid}, 32'd0);

    // saturation of the 2-bit counter
    ivalid = 1'b1; iaddr = 32'h0;
    dvalid = 1'b1; daddr = 32'h40;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("sat%0d", i), {30'd0, s_conflicts},
          (i < 2) ? 32'(i + 1) : 32'd3);
      chk($sformatf("cnt%0d", i), {16'd0, conflicts}, 32'(i + 1));
    end
    ivalid = 1'b0; dvalid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
